// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - accumulator sequencer driving an external ALU and a req/ack memory bank
module alu_seq_ctrl #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] ACC_RST     = '0,
  parameter int                MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [3:0] OP_LDA = 4'hD;
  localparam logic [3:0] OP_STA = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic              zero_q;
  logic [DATA_W-1:0] b_q;
  logic [3:0]        op_q;
  logic [3:0]        addr_q;
  logic              req_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0] in_op;
  logic       in_bin;
  logic       in_lda;
  logic       in_sta;
  logic       in_ill;
  logic       timeout_hit;

  assign in_op  = instr[7:4];
  assign in_bin = (in_op <= 4'h4);
  assign in_lda = (in_op == OP_LDA);
  assign in_sta = (in_op == OP_STA);
  assign in_ill = (in_op == OP_ILL);

  // Final allowed wait cycle; an ack arriving in this same cycle still wins.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (cnt_q == CNT_LAST);

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = acc_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = acc_q;
  assign acc         = acc_q;
  assign zero        = zero_q;
  assign done        = done_q;
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_RST;
      zero_q  <= (ACC_RST == '0);
      b_q     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q   <= in_op;
            addr_q <= instr[3:0];
            cnt_q  <= '0;
            if (in_ill) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (in_sta) begin
              state_q <= S_WR;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
            end else if (in_bin || in_lda) begin
              state_q <= S_RD;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (op_q == OP_LDA) begin
              acc_q   <= mem_rdata;
              zero_q  <= (mem_rdata == '0);
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              b_q     <= mem_rdata;
              state_q <= S_EXEC;
            end
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          acc_q   <= alu_y;
          zero_q  <= (alu_y == '0);
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_WR: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Accumulator-side sequencer that drives the 8-bit ALU's A/B/opcode inputs and consumes its combinational Y result.
- Accepts one-byte instructions over a valid/ready handshake and fetches operand B from the register/memory bank via a req/ack port.
- Executes the ALU op, writes the result back into the accumulator, and performs load/store of the accumulator.
- Sits between the instruction fetch path and the ALU + memory bank in the qtcore datapath.

Parameters:
- DATA_W, 8: accumulator, operand and memory data width; must match the ALU width.
- ACC_RST, 8'h00: accumulator reset value.
- MEM_TIMEOUT, 0: maximum cycles mem_req is held without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  8  instruction {op[3:0], addr[3:0]}.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE; the instruction is accepted when valid&&ready at a clk edge.
- alu_a  out  DATA_W  to the ALU A input; always equals acc.
- alu_b  out  DATA_W  to the ALU B input; the registered operand b_reg.
- alu_op  out  4  to the ALU opcode input; the registered op field.
- alu_y  in  DATA_W  ALU result.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  4  latched addr field.
- mem_wdata  out  DATA_W  equals acc.
- mem_rdata  in  DATA_W  read data; valid when mem_ack is high.
- mem_ack  in  1  completes the current access.
- acc  out  DATA_W  accumulator.
- zero  out  1  registered flag, (acc == 0).
- done  out  1  one-cycle pulse at instruction completion.
- err  out  1  one-cycle pulse coincident with done on an illegal op or a timeout.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=ACC_RST, zero=(ACC_RST==0), b_reg=0, op_reg=0, addr=0, mem_req=0, mem_we=0, done=0, err=0, timeout counter=0. instr_ready=1 once in IDLE.
- Op decode:
  - 0x0-0x4 (ADD, SUB, AND, OR, XOR): binary; B=mem[addr].
  - 0x5-0xC (SHL, SHR, SHL4, ROL, ROR, DEC, INV, CLR): unary; addr ignored, no memory access.
  - 0xD: LDA.
  - 0xE: STA.
  - 0xF: illegal.
- FSM states: IDLE, RD, EXEC, WR, DONE.
- IDLE: on accept, latch op/addr. Binary or LDA -> RD. STA -> WR. Unary -> EXEC. Illegal -> DONE with err.
- RD: mem_req=1, mem_we=0, addr held stable. On mem_ack: LDA loads acc=mem_rdata -> DONE; binary ops load b_reg=mem_rdata -> EXEC.
- EXEC: exactly one cycle; alu_op=op_reg. acc<=alu_y at the exiting edge -> DONE.
- WR: mem_req=1, mem_we=1, mem_wdata=acc. On mem_ack -> DONE. acc is unchanged.
- DONE: done=1 for one cycle (err=1 too if flagged) -> IDLE.
- zero is updated at every edge where acc is written, so it is valid in the DONE cycle.
- Latency from the accept edge to the done cycle:
  - illegal: 1 cycle.
  - unary: 2 cycles.
  - LDA/STA: N+1 cycles.
  - binary: N+2 cycles.
  - N = cycles spent in RD/WR, with N >= 1; mem_ack in the first RD/WR cycle gives N=1.
- Timeout (MEM_TIMEOUT>0):
  - The counter clears on entering RD/WR and increments each cycle without mem_ack.
  - If mem_ack is absent in the MEM_TIMEOUT-th cycle, go to DONE with err; mem_req drops after exactly MEM_TIMEOUT cycles.
  - acc and b_reg are unchanged on timeout.
  - mem_ack in that same final cycle wins: normal completion, no err.
- Arithmetic: all results are mod 2^DATA_W; carry and borrow are discarded.
- instr_valid while not IDLE: ignored; it is not accepted until ready.
- mem_ack outside RD/WR: ignored.
- Reset asserted mid RD/WR: mem_req drops asynchronously; no partial write to acc.

Test Plan:
1. Reset with instr_valid=0 -> acc=00, zero=1, instr_ready=1, mem_req=0, done=0, err=0.
2. instr=0xD3, mem_ack after 3 cycles with rdata=0x5A -> mem_req/mem_we=0/addr=3 held all 3 cycles; acc=0x5A, zero=0; done one cycle after the ack edge; instr_ready low until IDLE.
3. acc=0x5A, instr=0x07, ack first cycle rdata=0xB0 -> alu_op=0, alu_b=0xB0 in EXEC; acc=0x0A (wrap).
   Then instr=0x17 rdata=0x0A -> acc=0x00, zero=1.
4. acc=0x81, instr=0x80 (ROL) -> no mem_req; acc=0x03, done exactly 2 cycles after accept.
   Then instr=0xC0 (CLR) -> acc=0x00, zero=1.
5. MEM_TIMEOUT=4, acc=0x3C, instr=0xE9, no ack -> mem_req=1, mem_we=1, addr=9, wdata=0x3C for exactly 4 cycles; then done=err=1 for one cycle, acc=0x3C.
   Repeat with ack in cycle 4 -> done=1, err=0.
6. instr=0xF0 -> done=err=1 one cycle after accept, acc unchanged.
   instr_valid held during a busy RD -> no second accept.
   rst_n pulsed low mid-RD -> mem_req=0 immediately, state IDLE, acc=ACC_RST.
